oddr2: RTL and testbench

//   Behavioural double-data-rate output register (one bit lane, replicated WIDTH times).
//   - d1 is driven on q during the high phase of clk; d0 during the low phase.
//   - Used for DDR data pads and for forwarding a clock to a pin
//     (ddr_clkout ties d0=0, d1=1, so q reproduces clk).
//   - Sits directly in front of the output pad.

---
 rtl/oddr2_lane.sv | 64 ++++++
 rtl/oddr2.sv | 49 ++++
 tb/tb_oddr2.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/oddr2_lane.sv
// One DDR output bit. q is the XOR of a rising-edge flop and a falling-edge flop. Only one of
// the two flops changes at each edge, so q behaves as a single register clocked on both edges.
module oddr2_lane #(
  parameter logic INIT  = 1'b0,
  parameter logic SRVAL = 1'b0,
  parameter bit   IS_C0 = 1'b0,
  parameter bit   IS_C1 = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic d0,
  input  logic d1,
  output logic q
);

  logic rise_reg = INIT;
  logic fall_reg = 1'b0;
  logic hold_reg = INIT;
  logic rise_next;
  logic fall_next;

  // Each flop stores (wanted q) XOR (the other flop), so the XOR output equals the wanted q.
  always_comb begin
    rise_next = rise_reg;
    if (rst)
      rise_next = SRVAL ^ fall_reg;
    else if (ce)
      rise_next = (IS_C0 ? hold_reg : d1) ^ fall_reg;
  end

  always_comb begin
    fall_next = fall_reg;
    if (rst)
      fall_next = SRVAL ^ rise_reg;
    else if (ce)
      fall_next = (IS_C1 ? hold_reg : d0) ^ rise_reg;
  end

  always_ff @(posedge clk) rise_reg <= rise_next;
  always_ff @(negedge clk) fall_reg <= fall_next;

  // The hold flop captures the data for the opposite phase on the capturing edge.
  generate
    if (IS_C0) begin : g_hold_fall
      always_ff @(negedge clk) begin
        if (rst)
          hold_reg <= SRVAL;
        else if (ce)
          hold_reg <= d1;
      end
    end else begin : g_hold_rise
      always_ff @(posedge clk) begin
        if (rst)
          hold_reg <= SRVAL;
        else if (ce)
          hold_reg <= d0;
      end
    end
  endgenerate

  assign q = rise_reg ^ fall_reg;

endmodule

// File: rtl/oddr2.sv
// WIDTH-lane DDR output register. Each lane drives d1 during clk high and d0 during clk low,
// with optional capture alignment of both inputs to one clock edge.
module oddr2 #(
  parameter int    WIDTH         = 1,
  parameter logic  INIT          = 1'b0,
  parameter logic  SRVAL         = 1'b0,
  parameter string DDR_ALIGNMENT = "NONE"
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] q
);

  localparam string ALIGN_NONE = "NONE";
  localparam string ALIGN_C0   = "C0";
  localparam string ALIGN_C1   = "C1";

  localparam bit IS_NONE = (DDR_ALIGNMENT == ALIGN_NONE);
  localparam bit IS_C0   = (DDR_ALIGNMENT == ALIGN_C0);
  localparam bit IS_C1   = (DDR_ALIGNMENT == ALIGN_C1);

  generate
    if (!(IS_NONE || IS_C0 || IS_C1)) begin : g_bad_alignment
      $error("oddr2: DDR_ALIGNMENT must be NONE, C0 or C1");
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
      oddr2_lane #(
        .INIT  (INIT),
        .SRVAL (SRVAL),
        .IS_C0 (IS_C0),
        .IS_C1 (IS_C1)
      ) u_lane (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .d0  (d0[gi]),
        .d1  (d1[gi]),
        .q   (q[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_oddr2.sv
// Drives a NONE-aligned (INIT=1) and a C1-aligned (INIT=0) 4-lane oddr2 with shared stimulus
// and compares both outputs after every clock edge against a scoreboard of predicted values.
module tb_oddr2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ce  = 1'b1;
  logic [3:0] d0  = 4'h0;
  logic [3:0] d1  = 4'h0;
  logic [3:0] q_n;
  logic [3:0] q_c1;

  int checks = 0;
  int errors = 0;

  // Reference state: q of each instance plus the C1 instance's captured d0.
  logic [3:0] m_n    = 4'hF;
  logic [3:0] m_c1   = 4'h0;
  logic [3:0] m_hold = 4'h0;
  logic [7:0] sb[$];
  logic [7:0] exp_v;

  oddr2 #(.WIDTH(4), .INIT(1'b1), .SRVAL(1'b0), .DDR_ALIGNMENT("NONE")) dut_n (
    .clk(clk), .rst(rst), .ce(ce), .d0(d0), .d1(d1), .q(q_n)
  );

  oddr2 #(.WIDTH(4), .INIT(1'b0), .SRVAL(1'b0), .DDR_ALIGNMENT("C1")) dut_c1 (
    .clk(clk), .rst(rst), .ce(ce), .d0(d0), .d1(d1), .q(q_c1)
  );

  always #5 clk = ~clk;

  // Predict the next edge from the current inputs, then advance to just after that edge.
  task automatic drive_edge(input logic r, input logic e, input logic [3:0] a0, input logic [3:0] a1);
    logic rising;
    rst = r; ce = e; d0 = a0; d1 = a1;
    rising = (clk == 1'b0);
    if (r) begin
      m_n = 4'h0; m_c1 = 4'h0; m_hold = 4'h0;
    end else if (e) begin
      if (rising) begin
        m_n = a1; m_c1 = a1; m_hold = a0;
      end else begin
        m_n = a0; m_c1 = m_hold;
      end
    end
    sb.push_back({m_n, m_c1});
    if (rising) @(posedge clk); else @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (q_n !== 4'hF) begin errors++; $display("FAIL init_none q=%h expected=%h", q_n, 4'hF); end
    checks++;
    if (q_c1 !== 4'h0) begin errors++; $display("FAIL init_c1 q=%h expected=%h", q_c1, 4'h0); end
    for (int i = 0; i < 14; i++) begin
      drive_edge((i >= 4 && i < 8), 1'b1, 4'h0, 4'hF);
      exp_v = sb.pop_front();
      checks += 2;
      if (q_n !== exp_v[7:4]) begin errors++; $display("FAIL reset_none edge=%0d q=%h expected=%h", i, q_n, exp_v[7:4]); end
      if (q_c1 !== exp_v[3:0]) begin errors++; $display("FAIL reset_c1 edge=%0d q=%h expected=%h", i, q_c1, exp_v[3:0]); end
      $display("reset edge=%0d rst=%0b q_n=%h q_c1=%h", i, rst, q_n, q_c1);
    end
  endtask

  task automatic test_clock_forward;
    for (int i = 0; i < 8; i++) begin
      drive_edge(1'b0, 1'b1, 4'h0, 4'hF);
      exp_v = sb.pop_front();
      checks += 2;
      if (q_n[0] !== clk) begin errors++; $display("FAIL clkfwd_track edge=%0d q=%b clk=%b", i, q_n[0], clk); end
      if (q_n !== exp_v[7:4]) begin errors++; $display("FAIL clkfwd edge=%0d q=%h expected=%h", i, q_n, exp_v[7:4]); end
      $display("clkfwd edge=%0d clk=%b q_n=%h", i, clk, q_n);
    end
  endtask

  task automatic test_data_pattern;
    for (int i = 0; i < 24; i++) begin
      if (i < 4) drive_edge(1'b0, 1'b1, 4'h0, 4'hF);
      else       drive_edge(1'b0, 1'b1, 4'hF, 4'h0);
      exp_v = sb.pop_front();
      checks += 2;
      if (q_n !== exp_v[7:4]) begin errors++; $display("FAIL pattern_none edge=%0d q=%h expected=%h", i, q_n, exp_v[7:4]); end
      if (q_c1 !== exp_v[3:0]) begin errors++; $display("FAIL pattern_c1 edge=%0d q=%h expected=%h", i, q_c1, exp_v[3:0]); end
      $display("pattern edge=%0d q_n=%h q_c1=%h", i, q_n, q_c1);
    end
  endtask

  task automatic test_clock_enable;
    logic [3:0] frozen;
    frozen = q_n;
    for (int i = 0; i < 10; i++) begin
      drive_edge(1'b0, (i >= 6), 4'($urandom), 4'($urandom));
      exp_v = sb.pop_front();
      checks += 2;
      if (i < 6 && q_n !== frozen) begin errors++; $display("FAIL ce_frozen edge=%0d q=%h held=%h", i, q_n, frozen); end
      if (q_n !== exp_v[7:4]) begin errors++; $display("FAIL ce_none edge=%0d q=%h expected=%h", i, q_n, exp_v[7:4]); end
      checks++;
      if (q_c1 !== exp_v[3:0]) begin errors++; $display("FAIL ce_c1 edge=%0d q=%h expected=%h", i, q_c1, exp_v[3:0]); end
      $display("ce edge=%0d ce=%0b q_n=%h q_c1=%h", i, ce, q_n, q_c1);
    end
  endtask

  task automatic test_c1_align;
    if (clk == 1'b1) drive_edge(1'b0, 1'b1, 4'h0, 4'h0);
    void'(sb.pop_front());
    for (int i = 0; i < 3; i++) begin
      drive_edge(1'b0, 1'b1, 4'hF, 4'h0);   // d0 valid only at the rising edge
      exp_v = sb.pop_front();
      drive_edge(1'b0, 1'b1, 4'h0, 4'h0);   // d0 gone before the falling edge
      exp_v = sb.pop_front();
      checks += 2;
      if (q_c1 !== 4'hF || q_c1 !== exp_v[3:0]) begin errors++; $display("FAIL c1_low_phase q=%h expected=%h", q_c1, 4'hF); end
      if (q_n !== 4'h0 || q_n !== exp_v[7:4]) begin errors++; $display("FAIL none_low_phase q=%h expected=%h", q_n, 4'h0); end
      $display("align cycle=%0d q_n=%h q_c1=%h", i, q_n, q_c1);
    end
  endtask

  task automatic test_width;
    for (int i = 0; i < 8; i++) begin
      drive_edge(1'b0, 1'b1, 4'h5, 4'hA);
      exp_v = sb.pop_front();
      checks += 2;
      if (q_n !== (clk ? 4'hA : 4'h5)) begin errors++; $display("FAIL width_lanes edge=%0d q=%h expected=%h", i, q_n, clk ? 4'hA : 4'h5); end
      if (q_c1 !== exp_v[3:0]) begin errors++; $display("FAIL width_c1 edge=%0d q=%h expected=%h", i, q_c1, exp_v[3:0]); end
      $display("width edge=%0d q_n=%h q_c1=%h", i, q_n, q_c1);
    end
  endtask

  task automatic test_back_to_back;
    logic r;
    r = 1'b0;
    for (int i = 0; i < 60; i++) begin
      // Reset pulses always span a rising edge and the falling edge after it.
      if (clk == 1'b0) r = ($urandom_range(0, 9) == 0);
      drive_edge(r, ($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom));
      exp_v = sb.pop_front();
      checks += 2;
      if (q_n !== exp_v[7:4]) begin errors++; $display("FAIL random_none edge=%0d q=%h expected=%h", i, q_n, exp_v[7:4]); end
      if (q_c1 !== exp_v[3:0]) begin errors++; $display("FAIL random_c1 edge=%0d q=%h expected=%h", i, q_c1, exp_v[3:0]); end
      $display("random edge=%0d rst=%0b ce=%0b d0=%h d1=%h q_n=%h q_c1=%h", i, rst, ce, d0, d1, q_n, q_c1);
    end
  endtask

  initial begin
    test_reset;
    test_clock_forward;
    test_data_pattern;
    test_clock_enable;
    test_c1_align;
    test_width;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
